mem_req_arbiter: RTL and testbench

- Shares the single-outstanding memory port of the mmu between two requesters: instruction fetch (F) and load/store (M).
- Sits between the core pipeline and the mmu request/response interface.
- Accepts ready/valid requests, issues one request pulse downstream, waits for the response pulse, then routes the response to the owner.
- Fixed priority to M, with a starvation guard for F.

---
 rtl/mem_req_arbiter_pkg.sv | 21 ++
 rtl/mem_arb_grant.sv | 48 ++++
 rtl/mem_req_arbiter.sv | 151 +++++++++++++++
 tb/tb_mem_req_arbiter.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_req_arbiter_pkg.sv
// Shared definitions for the memory request arbiter: request mode encoding,
// arbiter FSM states and transaction owner identifiers.
package mem_req_arbiter_pkg;

  typedef enum logic {
    MEMREQ_READ  = 1'b0,
    MEMREQ_WRITE = 1'b1
  } memreq_mode_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_RESP = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWNER_F = 1'b0,
    OWNER_M = 1'b1
  } arb_owner_t;

endpackage

// File: rtl/mem_arb_grant.sv
// Winner selection between fetch (F) and load/store (M) with a starvation
// counter that forces an F grant after STARVE_LIMIT back-to-back M wins.
module mem_arb_grant #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rstn,
  input  logic idle,
  input  logic f_valid,
  input  logic m_valid,
  output logic f_ready,
  output logic m_ready
);

  localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  logic [CW-1:0] starve_cnt;
  logic          starve_hit;

  assign starve_hit = (starve_cnt == CW'(STARVE_LIMIT));

  always_comb begin
    f_ready = 1'b0;
    m_ready = 1'b0;
    if (idle) begin
      if (f_valid && m_valid) begin
        if (starve_hit) f_ready = 1'b1;
        else            m_ready = 1'b1;
      end else if (f_valid) begin
        f_ready = 1'b1;
      end else if (m_valid) begin
        m_ready = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      starve_cnt <= '0;
    end else if (f_valid && f_ready) begin
      starve_cnt <= '0;
    end else if (m_valid && m_ready) begin
      if (!f_valid)        starve_cnt <= '0;
      else if (!starve_hit) starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// Two-requester arbiter for the single-outstanding mmu memory port.
// Optional response watchdog enabled with the ARB_TIMEOUT_EN macro.
//
// state     | meaning
// IDLE      | waiting for a request; readies offered to the winner
// ISSUE     | one-cycle downstream request pulse
// WAIT_RESP | waiting for the downstream response (or watchdog expiry)
module mem_req_arbiter
  import mem_req_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT   = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        f_req_valid,
  output logic        f_req_ready,
  input  logic        f_req_mode,
  input  logic [31:0] f_req_addr,
  input  logic [31:0] f_req_wdata,
  input  logic [3:0]  f_req_wstrb,
  output logic        f_resp_valid,
  output logic [31:0] f_resp_data,
  input  logic        m_req_valid,
  output logic        m_req_ready,
  input  logic        m_req_mode,
  input  logic [31:0] m_req_addr,
  input  logic [31:0] m_req_wdata,
  input  logic [3:0]  m_req_wstrb,
  output logic        m_resp_valid,
  output logic [31:0] m_resp_data,
  output logic        d_req_enable,
  output logic        d_req_mode,
  output logic [31:0] d_req_addr,
  output logic [31:0] d_req_wdata,
  output logic [3:0]  d_req_wstrb,
  input  logic        d_resp_enable,
  input  logic [31:0] d_resp_data,
  output logic        timeout_err
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  arb_state_t state, state_nxt;
  arb_owner_t owner;
  logic       f_take, m_take;
  logic       resp_hit, timeout_hit;

  mem_arb_grant #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_grant (
    .clk    (clk),
    .rstn   (rstn),
    .idle   (state == IDLE),
    .f_valid(f_req_valid),
    .m_valid(m_req_valid),
    .f_ready(f_req_ready),
    .m_ready(m_req_ready)
  );

  assign f_take       = f_req_valid && f_req_ready;
  assign m_take       = m_req_valid && m_req_ready;
  assign resp_hit     = (state == WAIT_RESP) && d_resp_enable;
  assign d_req_enable = (state == ISSUE);

`ifdef ARB_TIMEOUT_EN
  logic [31:0] wd_cnt;
  logic        timeout_q;

  // Counter sits at zero outside WAIT_RESP, so it reads 0 on the entry cycle.
  always_ff @(posedge clk) begin
    if (!rstn || state != WAIT_RESP) wd_cnt <= '0;
    else                             wd_cnt <= wd_cnt + 32'd1;
  end

  assign timeout_hit = (state == WAIT_RESP) && !d_resp_enable &&
                       (wd_cnt == 32'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rstn) timeout_q <= 1'b0;
    else       timeout_q <= timeout_hit;
  end

  assign timeout_err = timeout_q;
`else
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (f_take || m_take) state_nxt = ISSUE;
      ISSUE:     state_nxt = WAIT_RESP;
      WAIT_RESP: if (resp_hit || timeout_hit) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      owner       <= OWNER_F;
      d_req_mode  <= 1'b0;
      d_req_addr  <= '0;
      d_req_wdata <= '0;
      d_req_wstrb <= '0;
    end else if (m_take) begin
      owner       <= OWNER_M;
      d_req_mode  <= m_req_mode;
      d_req_addr  <= m_req_addr;
      d_req_wdata <= m_req_wdata;
      d_req_wstrb <= m_req_wstrb;
    end else if (f_take) begin
      owner       <= OWNER_F;
      d_req_mode  <= f_req_mode;
      d_req_addr  <= f_req_addr;
      d_req_wdata <= f_req_wdata;
      d_req_wstrb <= f_req_wstrb;
    end
  end

  // Watchdog expiry completes the transaction with zero data.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      f_resp_valid <= 1'b0;
      m_resp_valid <= 1'b0;
      f_resp_data  <= '0;
      m_resp_data  <= '0;
    end else begin
      f_resp_valid <= 1'b0;
      m_resp_valid <= 1'b0;
      if (resp_hit || timeout_hit) begin
        if (owner == OWNER_M) begin
          m_resp_valid <= 1'b1;
          m_resp_data  <= resp_hit ? d_resp_data : 32'h0;
        end else begin
          f_resp_valid <= 1'b1;
          f_resp_data  <= resp_hit ? d_resp_data : 32'h0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter: vector table of single transactions plus
// hand sequences for arbitration, starvation, stray responses, reset and timeout.
module tb_mem_req_arbiter;

  logic        clk = 1'b0;
  logic        rstn;
  logic        f_req_valid, f_req_ready, f_req_mode;
  logic [31:0] f_req_addr, f_req_wdata;
  logic [3:0]  f_req_wstrb;
  logic        f_resp_valid;
  logic [31:0] f_resp_data;
  logic        m_req_valid, m_req_ready, m_req_mode;
  logic [31:0] m_req_addr, m_req_wdata;
  logic [3:0]  m_req_wstrb;
  logic        m_resp_valid;
  logic [31:0] m_resp_data;
  logic        d_req_enable, d_req_mode;
  logic [31:0] d_req_addr, d_req_wdata;
  logic [3:0]  d_req_wstrb;
  logic        d_resp_enable;
  logic [31:0] d_resp_data;
  logic        timeout_err;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] last_f = 32'h0;
  logic [31:0] last_m = 32'h0;

  always #5 clk = ~clk;

  mem_req_arbiter #(
    .STARVE_LIMIT  (4),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .f_req_valid  (f_req_valid),
    .f_req_ready  (f_req_ready),
    .f_req_mode   (f_req_mode),
    .f_req_addr   (f_req_addr),
    .f_req_wdata  (f_req_wdata),
    .f_req_wstrb  (f_req_wstrb),
    .f_resp_valid (f_resp_valid),
    .f_resp_data  (f_resp_data),
    .m_req_valid  (m_req_valid),
    .m_req_ready  (m_req_ready),
    .m_req_mode   (m_req_mode),
    .m_req_addr   (m_req_addr),
    .m_req_wdata  (m_req_wdata),
    .m_req_wstrb  (m_req_wstrb),
    .m_resp_valid (m_resp_valid),
    .m_resp_data  (m_resp_data),
    .d_req_enable (d_req_enable),
    .d_req_mode   (d_req_mode),
    .d_req_addr   (d_req_addr),
    .d_req_wdata  (d_req_wdata),
    .d_req_wstrb  (d_req_wstrb),
    .d_resp_enable(d_resp_enable),
    .d_resp_data  (d_resp_data),
    .timeout_err  (timeout_err)
  );

  typedef struct {
    logic        use_m;
    logic        mode;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          delay;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs[5];

  function automatic void chk1(string name, logic act, logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endfunction

  function automatic void chk32(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic use_m, input logic mode, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] wstrb);
    if (use_m) begin
      m_req_mode = mode; m_req_addr = addr; m_req_wdata = wdata; m_req_wstrb = wstrb;
      m_req_valid = 1'b1;
    end else begin
      f_req_mode = mode; f_req_addr = addr; f_req_wdata = wdata; f_req_wstrb = wstrb;
      f_req_valid = 1'b1;
    end
  endtask

  // Called in the acceptance cycle; ends in the cycle the response pulse is visible.
  task automatic finish_txn(input logic own_m, input logic drop, input logic mode,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] wstrb, input int delay, input logic [31:0] rdata);
    tick();
    if (drop) begin
      if (own_m) m_req_valid = 1'b0;
      else       f_req_valid = 1'b0;
    end
    chk1("d_req_enable pulse", d_req_enable, 1'b1);
    chk1("d_req_mode", d_req_mode, mode);
    chk32("d_req_addr", d_req_addr, addr);
    chk32("d_req_wdata", d_req_wdata, wdata);
    chk32("d_req_wstrb", {28'h0, d_req_wstrb}, {28'h0, wstrb});
    chk1("f_resp_valid idle", f_resp_valid, 1'b0);
    chk1("m_resp_valid idle", m_resp_valid, 1'b0);
    repeat (delay) tick();
    chk1("d_req_enable one cycle", d_req_enable, 1'b0);
    chk32("d_req_addr hold", d_req_addr, addr);
    d_resp_enable = 1'b1;
    d_resp_data   = rdata;
    tick();
    d_resp_enable = 1'b0;
    d_resp_data   = 32'h0;
    if (own_m) last_m = rdata;
    else       last_f = rdata;
    chk1("f_resp_valid", f_resp_valid, !own_m);
    chk1("m_resp_valid", m_resp_valid, own_m);
    chk32("f_resp_data", f_resp_data, last_f);
    chk32("m_resp_data", m_resp_data, last_m);
    chk1("timeout_err normal", timeout_err, 1'b0);
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b0, 32'h0000_0100, 32'h0,         4'h0,    2, 32'hCAFE_F00D};
    vecs[1] = '{1'b1, 1'b1, 32'h0000_0200, 32'h1122_3344, 4'b0011, 1, 32'h0000_0000};
    vecs[2] = '{1'b1, 1'b0, 32'h0000_0304, 32'h0,         4'h0,    3, 32'hDEAD_BEEF};
    vecs[3] = '{1'b0, 1'b1, 32'h0000_0400, 32'hA5A5_5A5A, 4'hF,    1, 32'h1234_5678};
    vecs[4] = '{1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0,         4'h0,    5, 32'h0BAD_C0DE};

    rstn = 1'b0;
    f_req_valid = 1'b0; f_req_mode = 1'b0; f_req_addr = '0; f_req_wdata = '0; f_req_wstrb = '0;
    m_req_valid = 1'b0; m_req_mode = 1'b0; m_req_addr = '0; m_req_wdata = '0; m_req_wstrb = '0;
    d_resp_enable = 1'b0; d_resp_data = '0;
    tick(); tick();
    rstn = 1'b1;
    #1;

    chk1("reset d_req_enable", d_req_enable, 1'b0);
    chk32("reset d_req_addr", d_req_addr, 32'h0);
    chk1("reset f_resp_valid", f_resp_valid, 1'b0);
    chk32("reset m_resp_data", m_resp_data, 32'h0);
    chk1("reset timeout_err", timeout_err, 1'b0);
    chk1("no-valid f_req_ready", f_req_ready, 1'b0);
    chk1("no-valid m_req_ready", m_req_ready, 1'b0);

    for (int i = 0; i < 5; i++) begin
      drive_req(vecs[i].use_m, vecs[i].mode, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb);
      #1;
      chk1("vec f_req_ready", f_req_ready, !vecs[i].use_m);
      chk1("vec m_req_ready", m_req_ready, vecs[i].use_m);
      finish_txn(vecs[i].use_m, 1'b1, vecs[i].mode, vecs[i].addr, vecs[i].wdata,
                 vecs[i].wstrb, vecs[i].delay, vecs[i].rdata);
    end
    tick();

    // Simultaneous requests: M first, F granted in the response cycle.
    drive_req(1'b0, 1'b0, 32'h0000_0500, 32'h0, 4'h0);
    drive_req(1'b1, 1'b1, 32'h0000_0200, 32'h1122_3344, 4'b0011);
    #1;
    chk1("both m_req_ready", m_req_ready, 1'b1);
    chk1("both f_req_ready", f_req_ready, 1'b0);
    finish_txn(1'b1, 1'b1, 1'b1, 32'h0000_0200, 32'h1122_3344, 4'b0011, 1, 32'h5555_0001);
    chk1("after-M f_req_ready", f_req_ready, 1'b1);
    finish_txn(1'b0, 1'b1, 1'b0, 32'h0000_0500, 32'h0, 4'h0, 2, 32'h5555_0002);
    tick();

    // Starvation: F pending, M continuously valid.
    drive_req(1'b0, 1'b0, 32'h0000_0600, 32'h0, 4'h0);
    drive_req(1'b1, 1'b0, 32'h0000_0700, 32'h0, 4'h0);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk1("starve m_req_ready", m_req_ready, 1'b1);
      chk1("starve f_req_ready", f_req_ready, 1'b0);
      finish_txn(1'b1, 1'b0, 1'b0, 32'h0000_0700, 32'h0, 4'h0, 1, 32'h7700_0000 + k);
    end
    chk1("forced f_req_ready", f_req_ready, 1'b1);
    chk1("forced m_req_ready", m_req_ready, 1'b0);
    chk32("starve_cnt at limit", 32'(dut.u_grant.starve_cnt), 32'd4);
    m_req_valid = 1'b0;
    finish_txn(1'b0, 1'b1, 1'b0, 32'h0000_0600, 32'h0, 4'h0, 1, 32'h6600_0006);
    chk32("starve_cnt cleared", 32'(dut.u_grant.starve_cnt), 32'd0);
    tick();

    // Stray responses in IDLE and ISSUE are dropped.
    d_resp_enable = 1'b1; d_resp_data = 32'hBAD0_0001;
    tick();
    d_resp_enable = 1'b0;
    chk1("stray idle f_resp_valid", f_resp_valid, 1'b0);
    chk1("stray idle m_resp_valid", m_resp_valid, 1'b0);
    drive_req(1'b0, 1'b0, 32'h0000_0800, 32'h0, 4'h0);
    tick();
    f_req_valid = 1'b0;
    chk1("stray d_req_enable", d_req_enable, 1'b1);
    d_resp_enable = 1'b1; d_resp_data = 32'hBAD0_0002;
    tick();
    d_resp_enable = 1'b0;
    chk1("stray issue f_resp_valid", f_resp_valid, 1'b0);
    chk32("stray issue f_resp_data", f_resp_data, last_f);
    d_resp_enable = 1'b1; d_resp_data = 32'h0808_0808;
    tick();
    d_resp_enable = 1'b0;
    last_f = 32'h0808_0808;
    chk1("real resp f_resp_valid", f_resp_valid, 1'b1);
    chk32("real resp f_resp_data", f_resp_data, last_f);
    tick();
    chk1("real resp single pulse", f_resp_valid, 1'b0);

    // Reset during WAIT_RESP drops the transaction.
    drive_req(1'b1, 1'b1, 32'h0000_0900, 32'hFEED_0009, 4'hF);
    tick();
    m_req_valid = 1'b0;
    tick();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    last_f = 32'h0; last_m = 32'h0;
    d_resp_enable = 1'b1; d_resp_data = 32'h9999_9999;
    tick();
    d_resp_enable = 1'b0;
    for (int c = 0; c < 2; c++) begin
      chk1("post-reset m_resp_valid", m_resp_valid, 1'b0);
      chk1("post-reset f_resp_valid", f_resp_valid, 1'b0);
      chk32("post-reset m_resp_data", m_resp_data, 32'h0);
      chk32("post-reset d_req_addr", d_req_addr, 32'h0);
      chk32("post-reset d_req_wdata", d_req_wdata, 32'h0);
      chk1("post-reset d_req_enable", d_req_enable, 1'b0);
      chk1("post-reset timeout_err", timeout_err, 1'b0);
      tick();
    end

`ifdef ARB_TIMEOUT_EN
    // Watchdog: pulse at cycle 1, expiry response nine cycles later.
    last_f = 32'hABCD_0001;
    drive_req(1'b0, 1'b0, 32'h0000_0A00, 32'h0, 4'h0);
    finish_txn(1'b0, 1'b1, 1'b0, 32'h0000_0A00, 32'h0, 4'h0, 1, 32'hABCD_0001);
    tick();
    drive_req(1'b0, 1'b0, 32'h0000_0B00, 32'h0, 4'h0);
    tick();
    f_req_valid = 1'b0;
    chk1("timeout d_req_enable", d_req_enable, 1'b1);
    repeat (8) tick();
    chk1("timeout early f_resp_valid", f_resp_valid, 1'b0);
    tick();
    last_f = 32'h0;
    chk1("timeout f_resp_valid", f_resp_valid, 1'b1);
    chk32("timeout f_resp_data", f_resp_data, 32'h0);
    chk1("timeout_err pulse", timeout_err, 1'b1);
    chk1("timeout m_resp_valid", m_resp_valid, 1'b0);
    d_resp_enable = 1'b1; d_resp_data = 32'h1A7E_1A7E;
    tick();
    d_resp_enable = 1'b0;
    chk1("late resp f_resp_valid", f_resp_valid, 1'b0);
    chk1("late resp timeout_err", timeout_err, 1'b0);
    chk32("late resp f_resp_data", f_resp_data, 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
